// File: rtl/demux_route_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_route_sequencer_if
// Description : Request-side bundle for demux_route_sequencer.
//               req_valid/req_ready handshake carrying a destination channel
//               and data bit, plus the scan_start strobe.
//   master : requester (drives req_valid, req_dest, req_data, scan_start)
//   slave  : sequencer (drives req_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_route_sequencer_if;
  logic       req_valid;   // request present
  logic       req_ready;   // sequencer can accept this cycle
  logic [2:0] req_dest;    // destination channel, bit0->s0 .. bit2->s2
  logic       req_data;    // data bit to route
  logic       scan_start;  // start automatic scan of channels 0..7

  modport master (
    output req_valid,
    output req_dest,
    output req_data,
    output scan_start,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dest,
    input  req_data,
    input  scan_start,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/demux_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : demux_route_sequencer
// Description : Drives d/s0/s1/s2 of a downstream 1-to-8 demultiplexer.
//               Routes a single requested bit, or scans channels 0..7 with
//               d=1. Each route holds d and the selects for HOLD_CYCLES,
//               then drives d=0 for GAP_CYCLES with the selects unchanged.
// Ports       : clk, rst_n (async, active-low)
//               req_if      - request handshake (slave modport)
//               busy        - state is not IDLE
//               d, s0..s2   - demux data and select outputs
//               done        - one-cycle pulse when a route or scan finishes
//               route_count - completed channel routes, wraps at 256
// Revision    : 1.0 - initial release
// ============================================================================
module demux_route_sequencer #(
  parameter int HOLD_CYCLES = 4,  // 1..255
  parameter int GAP_CYCLES  = 1   // 0..255
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  demux_route_sequencer_if.slave     req_if,
  output logic                       busy,
  output logic                       d,
  output logic                       s0,
  output logic                       s1,
  output logic                       s2,
  output logic                       done,
  output logic [7:0]                 route_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] C_GAP_LAST  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic       C_HAS_GAP   = (GAP_CYCLES > 0);

  state_t     r_state, w_state;
  logic       r_scan,  w_scan;
  logic [7:0] r_cnt,   w_cnt;
  logic [2:0] r_sel,   w_sel;
  logic       r_data,  w_data;
  logic       r_d,     w_d;
  logic       r_done,  w_done;
  logic       r_busy,  w_busy;
  logic [7:0] r_count, w_count;
  logic       w_route_end;  // current route finished its hold (and gap)

  // Ready is combinational so a requester sees it in the same cycle; reset
  // forces it low even before the state register settles.
  assign req_if.req_ready = (r_state == ST_IDLE) && !req_if.scan_start && rst_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath / registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan  <= 1'b0;
      r_cnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_data  <= 1'b0;
      r_d     <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_scan  <= w_scan;
      r_cnt   <= w_cnt;
      r_sel   <= w_sel;
      r_data  <= w_data;
      r_d     <= w_d;
      r_done  <= w_done;
      r_busy  <= w_busy;
      r_count <= w_count;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_scan      = r_scan;
    w_cnt       = r_cnt;
    w_sel       = r_sel;
    w_data      = r_data;
    w_d         = r_d;
    w_done      = 1'b0;
    w_count     = r_count;
    w_route_end = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_d = 1'b0;
        if (req_if.scan_start) begin
          w_scan  = 1'b1;
          w_sel   = 3'd0;
          w_data  = 1'b1;
          w_d     = 1'b1;
          w_cnt   = 8'd0;
          w_state = ST_DRIVE;
        end else if (req_if.req_valid && req_if.req_ready) begin
          w_sel   = req_if.req_dest;
          w_data  = req_if.req_data;
          w_d     = req_if.req_data;
          w_cnt   = 8'd0;
          w_state = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_count = r_count + 8'd1;
          w_cnt   = 8'd0;
          if (C_HAS_GAP) begin
            w_state = ST_GAP;
            w_d     = 1'b0;
          end else begin
            w_route_end = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      ST_GAP: begin
        if (r_cnt == C_GAP_LAST) begin
          w_cnt       = 8'd0;
          w_route_end = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_d     = 1'b0;
      end
    endcase

    // Post-gap decision: a scan steps straight to the next channel with no
    // IDLE cycle; anything else returns to IDLE with a single done pulse.
    if (w_route_end) begin
      if (r_scan && (r_sel != 3'd7)) begin
        w_sel   = r_sel + 3'd1;
        w_d     = r_data;
        w_state = ST_DRIVE;
      end else begin
        w_scan  = 1'b0;
        w_d     = 1'b0;
        w_done  = 1'b1;
        w_state = ST_IDLE;
      end
    end

    w_busy = (w_state != ST_IDLE);
  end

  assign busy        = r_busy;
  assign d           = r_d;
  assign s0          = r_sel[0];
  assign s1          = r_sel[1];
  assign s2          = r_sel[2];
  assign done        = r_done;
  assign route_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_demux_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_route_sequencer
// Description : Self-checking bench for demux_route_sequencer with default
//               HOLD_CYCLES=4, GAP_CYCLES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_route_sequencer;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy, d, s0, s1, s2, done;
  logic [7:0] route_count;
  logic [2:0] sel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_count;
  logic [2:0] prev_sel;
  logic       prev_d;
  logic       mon_en;

  always #5 clk = ~clk;

  demux_route_sequencer_if rif ();

  demux_route_sequencer #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (rif),
    .busy        (busy),
    .d           (d),
    .s0          (s0),
    .s1          (s1),
    .s2          (s2),
    .done        (done),
    .route_count (route_count)
  );

  assign sel = {s2, s1, s0};

  typedef struct {
    logic [2:0] dest;
    logic       data;
    logic [2:0] exp_sel;
    logic       exp_d;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge, and watch that the
  // selects only move when d was low in the previous cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en && (sel !== prev_sel)) begin
      check("sel_change_while_d_high", {31'd0, prev_d}, 32'd0);
    end
    prev_sel = sel;
    prev_d   = d;
  endtask

  // Present a request and advance through the accepting edge.
  task automatic issue(input logic [2:0] dest, input logic data);
    int n;
    rif.req_valid = 1'b1;
    rif.req_dest  = dest;
    rif.req_data  = data;
    n = 0;
    while (!rif.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    tick();
    rif.req_valid = 1'b0;
  endtask

  // Full single route with cycle-by-cycle checks.
  task automatic route_once(input logic [2:0] dest, input logic data,
                            input logic [2:0] exp_sel, input logic exp_d);
    issue(dest, data);
    for (int i = 0; i < HOLD; i++) begin
      check("drive_d", {31'd0, d}, {31'd0, exp_d});
      check("drive_sel", {29'd0, sel}, {29'd0, exp_sel});
      check("drive_busy", {31'd0, busy}, 32'd1);
      check("drive_done", {31'd0, done}, 32'd0);
      tick();
    end
    for (int i = 0; i < GAP; i++) begin
      check("gap_d", {31'd0, d}, 32'd0);
      check("gap_sel", {29'd0, sel}, {29'd0, exp_sel});
      tick();
    end
    exp_count++;
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_ready", {31'd0, rif.req_ready}, 32'd1);
    check("end_count", {24'd0, route_count}, {24'd0, exp_count});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t1, t2;

    vecs[0] = '{dest: 3'd5, data: 1'b1, exp_sel: 3'b101, exp_d: 1'b1};
    vecs[1] = '{dest: 3'd0, data: 1'b1, exp_sel: 3'b000, exp_d: 1'b1};
    vecs[2] = '{dest: 3'd7, data: 1'b0, exp_sel: 3'b111, exp_d: 1'b0};
    vecs[3] = '{dest: 3'd2, data: 1'b1, exp_sel: 3'b010, exp_d: 1'b1};
    vecs[4] = '{dest: 3'd4, data: 1'b0, exp_sel: 3'b100, exp_d: 1'b0};
    vecs[5] = '{dest: 3'd1, data: 1'b1, exp_sel: 3'b001, exp_d: 1'b1};

    rif.req_valid  = 1'b0;
    rif.req_dest   = 3'd0;
    rif.req_data   = 1'b0;
    rif.scan_start = 1'b0;
    mon_en    = 1'b0;
    exp_count = 8'd0;
    prev_sel  = 3'd0;
    prev_d    = 1'b0;

    // ---------------- reset values ----------------
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready_low", {31'd0, rif.req_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_d", {31'd0, d}, 32'd0);
    check("rst_sel", {29'd0, sel}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {24'd0, route_count}, 32'd0);
    check("rst_ready", {31'd0, rif.req_ready}, 32'd1);
    prev_sel = sel;
    prev_d   = d;
    mon_en   = 1'b1;

    // ---------------- table-driven single routes ----------------
    for (int v = 0; v < 6; v++) begin
      route_once(vecs[v].dest, vecs[v].data, vecs[v].exp_sel, vecs[v].exp_d);
    end

    // ---------------- back-to-back with req_valid held ----------------
    rif.req_valid = 1'b1;
    rif.req_dest  = 3'd3;
    rif.req_data  = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int n = 0; n < 40 && t2 < 0; n++) begin
      if (rif.req_valid && rif.req_ready) begin
        if (t1 < 0) begin
          t1 = cyc + 1;
          tick();
          check("b2b_first_sel", {29'd0, sel}, 32'd3);
          rif.req_dest = 3'd6;
        end else begin
          t2 = cyc + 1;
          tick();
          check("b2b_second_sel", {29'd0, sel}, 32'd6);
          check("b2b_second_d", {31'd0, d}, 32'd1);
        end
      end else begin
        tick();
      end
    end
    rif.req_valid = 1'b0;
    check("b2b_spacing", t2 - t1, 32'd6);
    wait_done();
    exp_count = exp_count + 8'd2;
    check("b2b_count", {24'd0, route_count}, {24'd0, exp_count});
    tick();

    // ---------------- scan with simultaneous request ----------------
    rif.scan_start = 1'b1;
    rif.req_valid  = 1'b1;
    rif.req_dest   = 3'd2;
    rif.req_data   = 1'b0;
    #1;
    check("scan_ready_low", {31'd0, rif.req_ready}, 32'd0);
    tick();
    rif.scan_start = 1'b0;
    rif.req_valid  = 1'b0;
    for (int ch = 0; ch < 8; ch++) begin
      for (int h = 0; h < HOLD; h++) begin
        check("scan_d", {31'd0, d}, 32'd1);
        check("scan_sel", {29'd0, sel}, ch);
        check("scan_done_early", {31'd0, done}, 32'd0);
        tick();
      end
      for (int g = 0; g < GAP; g++) begin
        check("scan_gap_d", {31'd0, d}, 32'd0);
        check("scan_gap_sel", {29'd0, sel}, ch);
        tick();
      end
    end
    exp_count = exp_count + 8'd8;
    check("scan_done", {31'd0, done}, 32'd1);
    check("scan_busy", {31'd0, busy}, 32'd0);
    check("scan_count", {24'd0, route_count}, {24'd0, exp_count});
    tick();
    check("scan_done_once", {31'd0, done}, 32'd0);

    // ---------------- reset mid-route ----------------
    issue(3'd7, 1'b1);
    tick();
    check("midrst_driving", {31'd0, d}, 32'd1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_d", {31'd0, d}, 32'd0);
    check("midrst_sel", {29'd0, sel}, 32'd0);
    check("midrst_count", {24'd0, route_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    exp_count = 8'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_done_after", {31'd0, done}, 32'd0);
    end
    prev_sel = sel;
    prev_d   = d;
    mon_en   = 1'b1;
    route_once(3'd1, 1'b1, 3'b001, 1'b1);

    // ---------------- route_count wrap ----------------
    mon_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_count = 8'd0;
    prev_sel  = sel;
    prev_d    = d;
    mon_en    = 1'b1;
    for (int r = 0; r < 256; r++) begin
      logic bit_r;
      logic [2:0] dst;
      bit_r = r[0];
      dst   = r[2:0];
      route_once(dst, bit_r, dst, bit_r);
    end
    check("wrap_count_zero", {24'd0, route_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
